// File: rtl/inst_fetch_ctrl.sv
// Instruction-ROM fetch sequencer: walks the ROM from index 0 and presents each word over valid/ready.
// Optional retired-instruction counter is built only when FETCH_PERF_CNT_EN is defined.
module inst_fetch_ctrl #(
  parameter int WIDTH    = 32,
  parameter int NUM_INST = 15,
  parameter int AW       = 4
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStart,
  input  logic             iReady,
  output logic [AW-1:0]    oRomAddr,
  input  logic [WIDTH-1:0] iRomData,
  output logic             oValid,
  output logic [WIDTH-1:0] oInst,
  output logic [WIDTH-1:0] oPc,
  output logic [6:0]       oOpcode,
  output logic [4:0]       oRD,
  output logic [2:0]       oFunct3,
  output logic [4:0]       oRS1,
  output logic [4:0]       oRS2,
  output logic [6:0]       oFunct7,
  output logic             oBusy,
  output logic             oDone,
  output logic [15:0]      oInstCount
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, OUT, DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      inst_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (iStart) begin
        idx_d   = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // A zero word is the terminator and is never handed downstream.
        if (iRomData == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          inst_d  = iRomData;
          pc_d    = {{(WIDTH-AW){1'b0}}, idx_q} << 2;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: if (iReady) begin
        valid_d = 1'b0;
        if (idx_q == AW'(NUM_INST-1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: if (iStart) begin
        done_d  = 1'b0;
        idx_d   = '0;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oRomAddr = idx_q;
  assign oValid   = valid_q;
  assign oInst    = inst_q;
  assign oPc      = pc_q;
  assign oOpcode  = inst_q[6:0];
  assign oRD      = inst_q[11:7];
  assign oFunct3  = inst_q[14:12];
  assign oRS1     = inst_q[19:15];
  assign oRS2     = inst_q[24:20];
  assign oFunct7  = inst_q[31:25];
  assign oBusy    = (state_q == FETCH) || (state_q == LOAD) || (state_q == OUT);
  assign oDone    = done_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt_q;
  logic        start_acc, accept;

  assign start_acc = iStart && ((state_q == IDLE) || (state_q == DONE));
  assign accept    = valid_q && iReady;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)                          cnt_q <= '0;
    else if (start_acc)                  cnt_q <= '0;
    else if (accept && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign oInstCount = cnt_q;
`else
  assign oInstCount = 16'h0000;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed corner sequences, a field-decode table and randomized ROM/ready runs.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, ready, start1, ready1;
  logic [3:0]  rom_addr;
  logic [1:0]  rom_addr1;
  logic [31:0] rom_data, rom_data1;
  logic        valid, valid1, busy, busy1, done, done1;
  logic [31:0] inst, inst1, pc, pc1;
  logic [6:0]  opcode, opcode1, f7, f71;
  logic [4:0]  rd, rd1, rs1, rs11, rs2, rs21;
  logic [2:0]  f3, f31;
  logic [15:0] cnt, cnt1;

  logic [31:0] rom0 [0:14];
  logic [31:0] rom1 [0:3];

  int total = 0, passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data  <= rom0[rom_addr];
  always @(posedge clk) rom_data1 <= rom1[rom_addr1];

  inst_fetch_ctrl #(.WIDTH(32), .NUM_INST(15), .AW(4)) dut (
    .iClk(clk), .iRstN(rst_n), .iStart(start), .iReady(ready),
    .oRomAddr(rom_addr), .iRomData(rom_data), .oValid(valid), .oInst(inst), .oPc(pc),
    .oOpcode(opcode), .oRD(rd), .oFunct3(f3), .oRS1(rs1), .oRS2(rs2), .oFunct7(f7),
    .oBusy(busy), .oDone(done), .oInstCount(cnt));

  inst_fetch_ctrl #(.WIDTH(32), .NUM_INST(4), .AW(2)) dut4 (
    .iClk(clk), .iRstN(rst_n), .iStart(start1), .iReady(ready1),
    .oRomAddr(rom_addr1), .iRomData(rom_data1), .oValid(valid1), .oInst(inst1), .oPc(pc1),
    .oOpcode(opcode1), .oRD(rd1), .oFunct3(f31), .oRS1(rs11), .oRS2(rs21), .oFunct7(f71),
    .oBusy(busy1), .oDone(done1), .oInstCount(cnt1));

  typedef struct {
    int          idx;
    logic [31:0] word;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
  } vec_t;

  vec_t tbl [3];

  // Reference model: presented sequence is the ROM prefix before the first zero, capped at the ROM depth.
  logic [31:0] exp_w [$];
  logic [31:0] exp_p [$];
  int          n_exp;
  logic [31:0] rec_inst [15];
  logic [6:0]  rec_op [15], rec_f7 [15];
  logic [4:0]  rec_rd [15], rec_rs1 [15], rec_rs2 [15];
  logic [2:0]  rec_f3 [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int exp_cnt(input int n);
`ifdef FETCH_PERF_CNT_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic build_model();
    exp_w.delete(); exp_p.delete();
    for (int i = 0; i < 15; i++) begin
      if (rom0[i] == 32'h0) break;
      exp_w.push_back(rom0[i]);
      exp_p.push_back(32'(i * 4));
    end
    n_exp = exp_w.size();
  endtask

  task automatic run0(input bit rnd);
    int steps = 0, prev = -1, npres = 0, k;
    bit hold;
    logic [31:0] h_inst, h_pc;
    while (!done && steps < 400) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = 1'b0;
      if (valid) begin
        if (ready) begin
          if (exp_w.size() == 0) chk("extra word presented", 32'(npres + 1), 32'(n_exp));
          else begin
            chk("presented word", inst, exp_w.pop_front());
            chk("presented pc", pc, exp_p.pop_front());
          end
          k = int'(pc >> 2);
          if (k < 15) begin
            rec_inst[k] = inst; rec_op[k] = opcode; rec_rd[k] = rd; rec_f3[k] = f3;
            rec_rs1[k] = rs1; rec_rs2[k] = rs2; rec_f7[k] = f7;
          end
          if (!rnd && prev >= 0) chk("throughput cycles", 32'(steps - prev), 32'd3);
          prev = steps;
          npres++;
        end else begin
          hold = 1'b1; h_inst = inst; h_pc = pc;
        end
      end
      step(); steps++;
      if (hold) begin
        chk("hold valid", 32'(valid), 32'd1);
        chk("hold inst", inst, h_inst);
        chk("hold pc", pc, h_pc);
      end
    end
    chk("run reaches DONE", 32'(done), 32'd1);
    chk("words presented", 32'(npres), 32'(n_exp));
    chk("valid low in DONE", 32'(valid), 32'd0);
    chk("inst count", 32'(cnt), 32'(exp_cnt(npres)));
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] tgt);
    int n = 0;
    ready = 1'b1;
    while (!(valid && pc == tgt) && n < 200) begin step(); n++; end
    chk($sformatf("reach pc %0d", tgt), 32'(valid && pc == tgt), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 10) begin step(); n++; end
    chk("valid within bound", 32'(valid), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    ready = 1'b1;
    while (!done && n < 200) begin step(); n++; end
    chk("reach DONE", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    logic [31:0] pcs [$];

    rom0[0]  = 32'h00A08093; rom0[1]  = 32'h00208113; rom0[2]  = 32'h001101B3;
    rom0[3]  = 32'h00318213; rom0[4]  = 32'h40418233; rom0[5]  = 32'h00522023;
    rom0[6]  = 32'h00022283; rom0[7]  = 32'h0052C333; rom0[8]  = 32'h006363B3;
    rom0[9]  = 32'h40610533; rom0[10] = 32'h00A57593; rom0[11] = 32'h00159613;
    rom0[12] = 32'h0015D693; rom0[13] = 32'h00D60733; rom0[14] = 32'h00000000;
    rom1[0] = 32'h11111113; rom1[1] = 32'h22222233; rom1[2] = 32'h33333313; rom1[3] = 32'h44444433;

    tbl[0] = '{0, 32'h00A08093, 7'h13, 5'd1,  3'd0, 5'd1, 5'd10, 7'h00};
    tbl[1] = '{2, 32'h001101B3, 7'h33, 5'd3,  3'd0, 5'd2, 5'd1,  7'h00};
    tbl[2] = '{9, 32'h40610533, 7'h33, 5'd10, 3'd0, 5'd2, 5'd6,  7'h20};

    rst_n = 1'b0; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    #23;
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset inst", inst, 32'd0);
    chk("reset pc", pc, 32'd0);
    chk("reset busy/done", 32'({busy, done}), 32'd0);
    chk("reset rom addr", 32'(rom_addr), 32'd0);
    chk("reset count", 32'(cnt), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();

    // Full run with ready held high: latency, throughput, field decode, terminator handling.
    build_model();
    start = 1'b1; step(); start = 1'b0;
    lat = 1;
    while (!valid && lat < 10) begin step(); lat++; end
    chk("start-to-valid latency", 32'(lat), 32'd3);
    run0(1'b0);
    chk("full run count", 32'(cnt), 32'(exp_cnt(14)));
    for (int i = 0; i < 3; i++) begin
      int k;
      k = tbl[i].idx;
      chk($sformatf("tbl%0d inst", i), rec_inst[k], tbl[i].word);
      chk($sformatf("tbl%0d opcode", i), 32'(rec_op[k]), 32'(tbl[i].op));
      chk($sformatf("tbl%0d rd", i), 32'(rec_rd[k]), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d funct3", i), 32'(rec_f3[k]), 32'(tbl[i].f3));
      chk($sformatf("tbl%0d rs1", i), 32'(rec_rs1[k]), 32'(tbl[i].rs1));
      chk($sformatf("tbl%0d rs2", i), 32'(rec_rs2[k]), 32'(tbl[i].rs2));
      chk($sformatf("tbl%0d funct7", i), 32'(rec_f7[k]), 32'(tbl[i].f7));
    end

    // Backpressure on the word at index 2.
    pulse_start();
    wait_pc(32'd8);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp valid", 32'(valid), 32'd1);
      chk("bp inst", inst, 32'h001101B3);
      chk("bp pc", pc, 32'd8);
      chk("bp rom addr", 32'(rom_addr), 32'd2);
    end
    ready = 1'b1;
    step();
    chk("bp accepted", 32'(valid), 32'd0);
    wait_valid();
    chk("bp next pc", pc, 32'd12);
    wait_done();

    // Restart request while presenting index 4 must be ignored.
    pulse_start();
    wait_pc(32'd16);
    ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step();
    chk("ignored start pc", pc, 32'd16);
    chk("ignored start valid/busy", 32'({valid, busy, done}), 32'b110);
    ready = 1'b1;
    step();
    wait_valid();
    chk("after ignore pc", pc, 32'd20);
    step();
    wait_valid();
    chk("after ignore pc2", pc, 32'd24);
    wait_done();
    pulse_start();
    chk("restart clears done", 32'(done), 32'd0);
    chk("restart rom addr", 32'(rom_addr), 32'd0);
    wait_valid();
    chk("restart pc", pc, 32'd0);
    chk("restart inst", inst, 32'h00A08093);
    wait_done();

    // Asynchronous reset while presenting index 9.
    pulse_start();
    wait_pc(32'd36);
    ready = 1'b0;
    chk("pre-reset inst", inst, 32'h40610533);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(valid), 32'd0);
    chk("async reset inst", inst, 32'd0);
    chk("async reset pc", pc, 32'd0);
    chk("async reset fields", 32'({opcode, rd, f3, rs1, rs2, f7}), 32'd0);
    chk("async reset busy/done", 32'({busy, done}), 32'd0);
    chk("async reset rom addr", 32'(rom_addr), 32'd0);
    chk("async reset count", 32'(cnt), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    pulse_start();
    chk("post-reset rom addr", 32'(rom_addr), 32'd0);
    wait_valid();
    chk("post-reset pc", pc, 32'd0);
    chk("post-reset inst", inst, 32'h00A08093);
    wait_done();

    // Four-entry ROM without a terminator: end-of-ROM guard.
    ready1 = 1'b1; start1 = 1'b1; step(); start1 = 1'b0;
    seen = 0;
    while (!done1 && seen < 100) begin
      if (valid1) pcs.push_back(pc1);
      step(); seen++;
    end
    chk("short rom done", 32'(done1), 32'd1);
    chk("short rom words", 32'(pcs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < pcs.size()) chk($sformatf("short rom pc%0d", i), pcs[i], 32'(i * 4));

    // Randomized ROM contents (zeros sprinkled in, sometimes none) with random ready.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 15; i++)
        rom0[i] = ($urandom_range(0, 6) == 0) ? 32'h0 : ($urandom | 32'h1);
      build_model();
      pulse_start();
      chk("count cleared on start", 32'(cnt), 32'd0);
      run0(1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
